alu_share_arbiter: RTL and testbench

//  Shares one combinational ALU instance between NUM_REQ requesters, e.g. the

---
 rtl/alu_share_arbiter_if.sv | 35 +++
 rtl/alu_share_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and the shared ALU arbiter.
//  master : requester/consumer side (drives requests, takes results)
//  slave  : arbiter side (grants requests, presents the result slot)
//  req_valid/req_ready : per-requester handshake, one bit per requester
//  req_a/req_b         : packed operands, requester i in [i*DATA_W +: DATA_W]
//  req_ctrl            : packed 3-bit ALU codes, requester i in [i*3 +: 3]
//  rsp_valid/rsp_ready : result slot handshake
//  rsp_data/rsp_id     : registered result and owning requester index
interface alu_share_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 32
);
    localparam int unsigned ID_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CTRL_W = 3;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*CTRL_W-1:0] req_ctrl;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic [ID_W-1:0]           rsp_id;

    modport master (
        output req_valid, req_a, req_b, req_ctrl, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters.
// The granted request is executed in the accept cycle and its result is
// registered into a single-entry output slot tagged with the requester index.
//  clock : rising-edge system clock
//  reset : asynchronous active-low reset
//  bus   : request ports and result slot (slave side of alu_share_arbiter_if)
module alu_share_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 32
) (
    input  logic               clock,
    input  logic               reset,
    alu_share_arbiter_if.slave bus
);
    localparam int unsigned ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CTRL_W  = 3;
    localparam int unsigned SHAMT_W = 5;

    logic [DATA_W-1:0] rsp_data_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic              rsp_valid_q;
    logic [ID_W-1:0]   rr_ptr;

    logic [DATA_W-1:0] a_arr    [NUM_REQ];
    logic [DATA_W-1:0] b_arr    [NUM_REQ];
    logic [CTRL_W-1:0] ctrl_arr [NUM_REQ];

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   next_ptr;
    int unsigned       idx;
    logic              slot_free_c;
    logic              accept_c;
    logic [NUM_REQ-1:0] req_ready_c;
    logic [DATA_W-1:0] a_sel;
    logic [DATA_W-1:0] b_sel;
    logic [CTRL_W-1:0] ctrl_sel;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W-1:0] alu_res;

    // Unpack the flat request buses into per-requester fields
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            a_arr[i]    = bus.req_a[i*DATA_W +: DATA_W];
            b_arr[i]    = bus.req_b[i*DATA_W +: DATA_W];
            ctrl_arr[i] = bus.req_ctrl[i*CTRL_W +: CTRL_W];
        end
    end

    // First valid requester at or after rr_ptr, wrapping
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_found && bus.req_valid[ID_W'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    // Reset gates ready so nothing is accepted while the slot is being cleared
    assign slot_free_c = !rsp_valid_q || bus.rsp_ready;
    assign accept_c    = reset && grant_found && slot_free_c;

    always_comb begin
        req_ready_c = '0;
        if (accept_c) begin
            req_ready_c[grant_idx] = 1'b1;
        end
    end

    assign next_ptr = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    assign a_sel    = a_arr[grant_idx];
    assign b_sel    = b_arr[grant_idx];
    assign ctrl_sel = ctrl_arr[grant_idx];

    // Shift codes only use the low five bits of operand B
    always_comb begin
        b_eff = b_sel;
        case (ctrl_sel)
            3'b001, 3'b011, 3'b101: b_eff = DATA_W'(b_sel[SHAMT_W-1:0]);
            default:                b_eff = b_sel;
        endcase
    end

    // Shared ALU; the unlisted code 010 is subtract
    always_comb begin
        alu_res = '0;
        case (ctrl_sel)
            3'b000:         alu_res = a_sel + b_eff;
            3'b001, 3'b011: alu_res = a_sel << b_eff;
            3'b101:         alu_res = a_sel >> b_eff;
            3'b100:         alu_res = a_sel ^ b_eff;
            3'b110:         alu_res = a_sel | b_eff;
            3'b111:         alu_res = a_sel & b_eff;
            default:        alu_res = a_sel - b_eff;
        endcase
    end

    // Result slot: load on accept, drain when taken without a reload
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rr_ptr      <= '0;
        end else if (accept_c) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= alu_res;
            rsp_id_q    <= grant_idx;
            rr_ptr      <= next_ptr;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed, table-driven bench for alu_share_arbiter with two requesters.
module tb_alu_share_arbiter;
    logic clock;
    logic reset;
    int   errors;
    int   checks;

    alu_share_arbiter_if #(.NUM_REQ(2), .DATA_W(32)) bus ();

    alu_share_arbiter #(.NUM_REQ(2), .DATA_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [2:0]  c0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [2:0]  c1;
        logic        rsp_ready;
        logic [1:0]  exp_ready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_id;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(input logic [1:0] valid,
                                input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] c0,
                                input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] c1,
                                input logic rdy, input logic [1:0] er, input logic ev,
                                input logic [31:0] ed, input logic eid);
        vec_t v;
        v.valid = valid; v.a0 = a0; v.b0 = b0; v.c0 = c0;
        v.a1 = a1; v.b1 = b1; v.c1 = c1; v.rsp_ready = rdy;
        v.exp_ready = er; v.exp_valid = ev; v.exp_data = ed; v.exp_id = eid;
        return v;
    endfunction

    task automatic drive(input logic [1:0] valid,
                         input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] c0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] c1,
                         input logic rdy);
        bus.req_valid = valid;
        bus.req_a     = {a1, a0};
        bus.req_b     = {b1, b0};
        bus.req_ctrl  = {c1, c0};
        bus.rsp_ready = rdy;
    endtask

    task automatic check(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, n, act, exp);
        end
    endtask

    task automatic check_slot(input string tag, input int n, input logic ev, input logic [31:0] ed, input logic eid);
        check({tag, "_rsp_valid"}, n, 32'(bus.rsp_valid), 32'(ev));
        check({tag, "_rsp_data"},  n, bus.rsp_data, ed);
        check({tag, "_rsp_id"},    n, 32'(bus.rsp_id), 32'(eid));
    endtask

    initial begin
        errors = 0;
        checks = 0;

        // Contention: grants alternate 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            vecs[i] = mk(2'b11, 32'd10, 32'd4, 3'b010, 32'hF0, 32'h0F, 3'b110, 1'b1,
                         (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1,
                         (i % 2 == 0) ? 32'd6 : 32'hFF, (i % 2 == 0) ? 1'b0 : 1'b1);
        end
        // Single op and the ALU code set, including shift masking and wraparound
        vecs[4]  = mk(2'b01, 32'd5, 32'd3, 3'b000, 0, 0, 3'b000, 1'b1, 2'b01, 1'b1, 32'd8, 1'b0);
        vecs[5]  = mk(2'b01, 32'd1, 32'h21, 3'b001, 0, 0, 3'b000, 1'b1, 2'b01, 1'b1, 32'd2, 1'b0);
        vecs[6]  = mk(2'b10, 0, 0, 3'b000, 32'h8000_0000, 32'h3F, 3'b101, 1'b1, 2'b10, 1'b1, 32'd1, 1'b1);
        vecs[7]  = mk(2'b10, 0, 0, 3'b000, 32'h0F0F, 32'h00FF, 3'b100, 1'b1, 2'b10, 1'b1, 32'h0FF0, 1'b1);
        vecs[8]  = mk(2'b01, 32'hFF00_FF00, 32'h0FF0_0FF0, 3'b111, 0, 0, 3'b000, 1'b1, 2'b01, 1'b1, 32'h0F00_0F00, 1'b0);
        vecs[9]  = mk(2'b01, 32'd3, 32'hFFFF_FFE4, 3'b011, 0, 0, 3'b000, 1'b1, 2'b01, 1'b1, 32'h30, 1'b0);
        vecs[10] = mk(2'b10, 0, 0, 3'b000, 32'd0, 32'd1, 3'b010, 1'b1, 2'b10, 1'b1, 32'hFFFF_FFFF, 1'b1);
        vecs[11] = mk(2'b01, 32'hFFFF_FFFF, 32'd2, 3'b000, 0, 0, 3'b000, 1'b1, 2'b01, 1'b1, 32'd1, 1'b0);
        // Idle with consumer ready: slot drains, data held
        vecs[12] = mk(2'b00, 0, 0, 3'b000, 0, 0, 3'b000, 1'b1, 2'b00, 1'b0, 32'd1, 1'b0);
        // Backpressure: accept into empty slot, stall three cycles, then drain+reload
        vecs[13] = mk(2'b11, 32'd7, 32'd2, 3'b010, 32'h10, 32'h20, 3'b000, 1'b0, 2'b10, 1'b1, 32'h30, 1'b1);
        for (int i = 14; i < 17; i++) begin
            vecs[i] = mk(2'b11, 32'd7, 32'd2, 3'b010, 32'h10, 32'h20, 3'b000, 1'b0, 2'b00, 1'b1, 32'h30, 1'b1);
        end
        vecs[17] = mk(2'b11, 32'd7, 32'd2, 3'b010, 32'h10, 32'h20, 3'b000, 1'b1, 2'b01, 1'b1, 32'd5, 1'b0);
        vecs[18] = mk(2'b00, 0, 0, 3'b000, 0, 0, 3'b000, 1'b1, 2'b00, 1'b0, 32'd5, 1'b0);

        // Reset held with live requests: nothing granted, slot stays empty
        reset = 1'b0;
        drive(2'b11, 32'd5, 32'd3, 3'b000, 32'd9, 32'd1, 3'b000, 1'b1);
        #1;
        check("rst_req_ready", 0, 32'(bus.req_ready), 32'h0);
        check_slot("rst", 0, 1'b0, 32'h0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clock);
            #1;
            check("rst_req_ready", i, 32'(bus.req_ready), 32'h0);
            check_slot("rst", i, 1'b0, 32'h0, 1'b0);
        end
        reset = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].valid, vecs[i].a0, vecs[i].b0, vecs[i].c0,
                  vecs[i].a1, vecs[i].b1, vecs[i].c1, vecs[i].rsp_ready);
            #1;
            check("vec_req_ready", i, 32'(bus.req_ready), 32'(vecs[i].exp_ready));
            @(posedge clock);
            #1;
            check_slot("vec", i, vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_id);
        end

        // Reset mid-operation: fill slot (rr_ptr moves to 1), then reset asynchronously
        drive(2'b01, 32'd5, 32'd3, 3'b000, 0, 0, 3'b000, 1'b0);
        #1;
        check("mid_req_ready", 0, 32'(bus.req_ready), 32'h1);
        @(posedge clock);
        #1;
        check_slot("mid_load", 0, 1'b1, 32'd8, 1'b0);
        drive(2'b00, 0, 0, 3'b000, 0, 0, 3'b000, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_slot("mid_async", 0, 1'b0, 32'h0, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        // rr_ptr cleared: requester 0 wins the tie
        drive(2'b11, 32'd5, 32'd3, 3'b000, 32'd9, 32'd1, 3'b000, 1'b1);
        #1;
        check("post_rst_req_ready", 0, 32'(bus.req_ready), 32'h1);
        @(posedge clock);
        #1;
        check_slot("post_rst", 0, 1'b1, 32'd8, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
